// File: rtl/ryuki_mem_pkg.sv
// Shared definitions for the ryuki data memory: lane count, width defaults,
// response bundle and the byte-address to word-index helper.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_WORDS
`define NUM_WORDS 1024
`endif

package ryuki_mem_pkg;

   localparam int BYTE_LANES     = 4;
   localparam int DEF_ADDR_WIDTH = `ADDR_WIDTH;
   localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEF_NUM_WORDS  = `NUM_WORDS;

   // One response beat as seen on the data bus.
   typedef struct packed {
      logic                      rvalid;
      logic                      err;
      logic [DEF_DATA_WIDTH-1:0] rdata;
   } mem_resp_t;

   // Word index of a byte address; the two lane-select bits are dropped
   // because the core never issues misaligned word accesses.
   function automatic logic [61:0] word_index(input logic [63:0] addr);
      return 62'(addr >> 2);
   endfunction

endpackage

// File: rtl/ryuki_bram_be.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are never cleared.
module ryuki_bram_be
   import ryuki_mem_pkg::*;
#(
   parameter int    NUM_WORDS  = DEF_NUM_WORDS,
   parameter int    IDX_W      = $clog2(DEF_NUM_WORDS),
   parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [BYTE_LANES-1:0] be_i,
   input  logic                  re_i,
   input  logic [IDX_W-1:0]      addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   // Byte-lane writes and synchronous word read share the single port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int n = 0; n < BYTE_LANES; n++) begin
            if (be_i[n]) mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
         end
      end
      if (re_i) rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/ryuki_data_memory.sv
// Single-port data RAM on the core req/gnt/rvalid bus. Zero-wait grant,
// one-cycle response, range error for addresses beyond the array.
module ryuki_data_memory
   import ryuki_mem_pkg::*;
#(
   parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int    NUM_WORDS  = DEF_NUM_WORDS,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [BYTE_LANES-1:0] be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o
);

   localparam int IDX_W = $clog2(NUM_WORDS);

   logic [61:0]           idx_full_p0;
   logic                  addr_bad_p0;
   logic                  in_range_p0;
   logic                  gnt_p0;
   logic                  wr_en_p0;
   logic                  rd_en_p0;

   logic                  vld_p1;
   logic                  err_p1;
   logic                  rd_p1;
   logic [DATA_WIDTH-1:0] hold_p1;
   logic [DATA_WIDTH-1:0] bram_rdata;
   mem_resp_t             resp;

   // ---- p0: request decode, grant and range check ----
   assign gnt_p0      = req_i & ~rst_i;
   assign idx_full_p0 = word_index(64'(addr_i));
   // Unknown address or lanes cannot be trusted to hit a real word.
   assign addr_bad_p0 = $isunknown({addr_i, be_i});
   assign in_range_p0 = ~addr_bad_p0 && (idx_full_p0 < 62'(NUM_WORDS));
   assign wr_en_p0    = gnt_p0 & we_i & in_range_p0;
   assign rd_en_p0    = gnt_p0 & ~we_i & in_range_p0;
   assign gnt_o       = gnt_p0;

   ryuki_bram_be #(
      .NUM_WORDS  (NUM_WORDS),
      .IDX_W      (IDX_W),
      .DATA_WIDTH (DATA_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_bram (
      .clk_i   (clk_i),
      .we_i    (wr_en_p0),
      .be_i    (be_i),
      .re_i    (rd_en_p0),
      .addr_i  (idx_full_p0[IDX_W-1:0]),
      .wdata_i (wdata_i),
      .rdata_o (bram_rdata)
   );

   // ---- p1: response register; hold_p1 remembers the last driven rdata ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         rd_p1   <= 1'b0;
         hold_p1 <= '0;
      end else begin
         vld_p1  <= gnt_p0;
         err_p1  <= gnt_p0 & ~in_range_p0;
         rd_p1   <= rd_en_p0;
         hold_p1 <= resp.rdata;
      end
   end

   // Reset masks the outputs at once so a pending response is dropped.
   always_comb begin
      resp = '0;
      if (!rst_i) begin
         resp.rvalid = vld_p1;
         resp.err    = err_p1;
         if (rd_p1)       resp.rdata = bram_rdata;
         else if (vld_p1) resp.rdata = '0;
         else             resp.rdata = hold_p1;
      end
   end

   assign rvalid_o = resp.rvalid;
   assign err_o    = resp.err;
   assign rdata_o  = resp.rdata;

endmodule

// File: tb/tb_ryuki_data_memory.sv
// Scoreboard bench for ryuki_data_memory: requests push their expected
// response, a negedge monitor pops and compares each rvalid beat.
module tb_ryuki_data_memory;

   localparam int NUM_WORDS = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   typedef struct {
      string       tag;
      int          cyc;
      logic        err;
      logic [31:0] rdata;
   } sb_item_t;

   sb_item_t    sb[$];
   logic [31:0] model [longint];
   int          cyc     = 0;
   int          n_check = 0;
   int          n_fail  = 0;

   ryuki_data_memory #(.NUM_WORDS(NUM_WORDS)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .we_i     (we_i),
      .be_i     (be_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_check++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk_i) begin
      sb_item_t e;
      if (rvalid_o === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("unexpected_rvalid", 32'(rvalid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            check_val({e.tag, "_lat"},   32'(cyc),   32'(e.cyc + 1));
            check_val({e.tag, "_err"},   32'(err_o), 32'(e.err));
            check_val({e.tag, "_rdata"}, rdata_o,    e.rdata);
         end
      end else if (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
         e = sb.pop_front();
         check_val({e.tag, "_missing_rvalid"}, 32'(rvalid_o), 32'd1);
      end
   end

   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
      sb_item_t    e;
      longint      idx;
      bit          oor;
      logic [31:0] w;
      idx = longint'(addr >> 2);
      oor = (idx >= NUM_WORDS);
      @(posedge clk_i); #1;
      req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
      e.tag = tag; e.cyc = cyc; e.err = oor;
      e.rdata = (oor || we) ? 32'd0 : (model.exists(idx) ? model[idx] : 32'hxxxxxxxx);
      sb.push_back(e);
      if (we && !oor) begin
         w = model.exists(idx) ? model[idx] : 32'd0;
         for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wdata[8*n +: 8];
         model[idx] = w;
      end
      #3 check_val({tag, "_gnt"}, 32'(gnt_o), 32'd1);
   endtask

   task automatic idle();
      @(posedge clk_i); #1;
      req_i = 1'b0; we_i = 1'b0;
      #3;
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100; be_i = 4'hF; wdata_i = 32'h5555AAAA;

      // Reset held with a live request
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #4;
         check_val("rst_gnt",    32'(gnt_o),    32'd0);
         check_val("rst_rvalid", 32'(rvalid_o), 32'd0);
         check_val("rst_rdata",  rdata_o,       32'd0);
         check_val("rst_err",    32'(err_o),    32'd0);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0;

      // Write then read-after-write
      access("wr100", 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
      access("rd100", 1'b0, 32'h100, 4'hF, 32'h0);
      idle();

      // Byte lanes, empty-lane write, idle hold of rdata
      access("wr200",  1'b1, 32'h200, 4'hF,    32'h11223344);
      access("wr200b", 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD);
      access("wr200z", 1'b1, 32'h200, 4'b0000, 32'hFFFFFFFF);
      access("rd200",  1'b0, 32'h203, 4'b0001, 32'h0);
      idle();
      idle();
      check_val("idle_rvalid", 32'(rvalid_o), 32'd0);
      check_val("idle_err",    32'(err_o),    32'd0);
      check_val("idle_hold",   rdata_o,       32'h11BB33DD);

      // Streaming: fill 8 words then read them back to back
      for (int i = 0; i < 8; i++)
         access("swr", 1'b1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i * 32'h111));
      for (int i = 0; i < 8; i++)
         access($sformatf("srd%0d", i), 1'b0, 32'(i * 4), 4'hF, 32'h0);
      idle();

      // Range errors and no wrap-around
      access("rd_oor",  1'b0, 32'h1000,     4'hF, 32'h0);
      access("wr_oor",  1'b1, 32'h1000,     4'hF, 32'h12345678);
      access("wr_top",  1'b1, 32'hFFFFFFFC, 4'hF, 32'h87654321);
      access("rd0",     1'b0, 32'h0,        4'hF, 32'h0);
      access("rd_last", 1'b1, 32'hFFC,      4'hF, 32'h0BADF00D);
      access("rd_lastr",1'b0, 32'hFFC,      4'hF, 32'h0);
      idle();
      idle();

      // Reset in the cycle after a granted read; concurrent write must be ignored
      @(posedge clk_i); #1;
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; be_i = 4'hF;
      #3 check_val("mrst_rd_gnt", 32'(gnt_o), 32'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100; wdata_i = 32'h0;
      #3;
      check_val("mrst_rvalid", 32'(rvalid_o), 32'd0);
      check_val("mrst_gnt",    32'(gnt_o),    32'd0);
      check_val("mrst_rdata",  rdata_o,       32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
      access("mrst_rd100", 1'b0, 32'h100, 4'hF, 32'h0);

      for (int i = 0; i < 3; i++) idle();
      check_val("sb_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
